// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS phase front end.
package dds_pkg;
  localparam int PHASE_W = 32;
  localparam int DIV_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SWEEP,
    DONE
  } dds_state_t;
endpackage

// File: rtl/dds_phase_gen_tick.sv
// Sample-rate divider: counts 0..div_i while running, ticks on match.
module sample_tick_gen
  import dds_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_i,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q + DIV_WIDTH'(1);
    if (!run_i || clr_i || tick_o)
      cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase accumulator with FTW handshake, sample divider
// and saturating linear frequency sweep.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_W,
  parameter int DIV_WIDTH   = DIV_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   sweep_en,
  input  logic                   sync_clr,
  input  logic [PHASE_WIDTH-1:0] ftw_in,
  input  logic                   ftw_valid,
  output logic                   ftw_ready,
  input  logic [PHASE_WIDTH-1:0] phase_offset,
  input  logic [DIV_WIDTH-1:0]   sample_div,
  input  logic [PHASE_WIDTH-1:0] sweep_step,
  input  logic [PHASE_WIDTH-1:0] sweep_stop,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   enable,
  output logic                   sweep_done
);

  dds_state_t state_q, state_d;

  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] pend_q, pend_d;
  logic [PHASE_WIDTH-1:0] act_q, act_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   en_q, en_d;

  logic                   active;
  logic                   tick;
  logic                   tick_eff;
  logic                   xfer;
  logic [PHASE_WIDTH-1:0] acc_nxt;
  logic [PHASE_WIDTH:0]   sweep_sum;

  assign ftw_ready  = (state_q == IDLE) || (state_q == RUN);
  assign sweep_done = (state_q == DONE);
  assign phase      = phase_q;
  assign enable     = en_q;

  assign xfer     = ftw_valid && ftw_ready;
  assign active   = run && (state_q != IDLE);
  assign tick_eff = tick && !sync_clr;
  assign acc_nxt  = acc_q + act_q;

  // Extra carry bit lets a huge step saturate instead of wrapping.
  assign sweep_sum = {1'b0, act_q} + {1'b0, sweep_step};

  sample_tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .run_i (active),
    .clr_i (sync_clr),
    .div_i (sample_div),
    .tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pend_d  = xfer ? ftw_in : pend_q;
    act_d   = act_q;
    phase_d = phase_q;
    en_d    = 1'b0;

    if (!run) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = sweep_en ? SWEEP : RUN;
          act_d   = pend_q;
        end
        RUN: begin
          if (tick_eff)
            act_d = pend_d;
        end
        SWEEP: begin
          if (tick_eff) begin
            if (sweep_sum >= {1'b0, sweep_stop}) begin
              act_d   = sweep_stop;
              state_d = DONE;
            end else begin
              act_d = sweep_sum[PHASE_WIDTH-1:0];
            end
          end
        end
        DONE: begin
          if (!sweep_en)
            state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end

    if (sync_clr) begin
      acc_d   = '0;
      phase_d = phase_offset;
    end else if (tick_eff) begin
      acc_d   = acc_nxt;
      phase_d = acc_nxt + phase_offset;
      en_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      phase_q <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      phase_q <= phase_d;
      en_q    <= en_d;
    end
  end

endmodule
